pattern_pwm: RTL and testbench



---
 rtl/pattern_pwm.sv | 126 ++++++++++++
 tb/tb_pattern_pwm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pattern_pwm.sv
// ---------------------------------------------------------------------------
// pattern_pwm
//   Serial pattern generator for the DDS sample datapath. A start request
//   latches an 8-bit pattern and a repeat count. The pattern is then shifted
//   out MSB-first on pwm_out and replayed (duty_num+1) times. Each bit is
//   held for BIT_CYCLES clocks.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   pwm_en    in   start request, sampled only while idle
//   duty_num  in   extra pattern repetitions (passes = duty_num+1)
//   PAT       in   pattern to emit, MSB first
//   pwm_out   out  serial pattern bit (registered)
//   busy      out  high while a sequence is being emitted (registered)
//   valid     out  one-cycle completion strobe (registered)
// ---------------------------------------------------------------------------
module pattern_pwm #(
    parameter int PAT_W      = 8,
    parameter int CNT_W      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] duty_num,
    input  logic [PAT_W-1:0] PAT,
    output logic             pwm_out,
    output logic             busy,
    output logic             valid
);

    // Counter widths are kept at least one bit wide so BIT_CYCLES=1 is legal.
    localparam int IDX_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(PAT_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(BIT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [PAT_W-1:0]   pat_q;
    logic [CNT_W-1:0]   rep_q;
    logic [CNT_W-1:0]   pass_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [IDX_W-1:0]   bit_idx_d;
    logic [HOLD_W-1:0]  hold_q;
    logic               pwm_q;
    logic               busy_q;
    logic               valid_q;

    // Index of the next bit to present once the current one has been held.
    always_comb begin
        bit_idx_d = bit_idx_q - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            pass_q    <= '0;
            bit_idx_q <= '0;
            hold_q    <= '0;
            pwm_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            // The completion strobe lives for a single cycle.
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pwm_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (pwm_en) begin
                        pat_q     <= PAT;
                        rep_q     <= duty_num;
                        pass_q    <= '0;
                        bit_idx_q <= IDX_MAX;
                        hold_q    <= '0;
                        // First bit appears on the accepting edge itself.
                        pwm_q     <= PAT[PAT_W-1];
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end else begin
                        hold_q <= '0;
                        if (bit_idx_q != '0) begin
                            bit_idx_q <= bit_idx_d;
                            pwm_q     <= pat_q[bit_idx_d];
                        end else if (pass_q == rep_q) begin
                            // Compare before incrementing so rep_q at its
                            // maximum never needs a wider pass counter.
                            state_q <= IDLE;
                            pwm_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            pass_q    <= pass_q + CNT_W'(1);
                            bit_idx_q <= IDX_MAX;
                            pwm_q     <= pat_q[PAT_W-1];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pwm_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out = pwm_q;
    assign busy    = busy_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_pattern_pwm.sv
// ---------------------------------------------------------------------------
// tb_pattern_pwm
//   Directed bench for pattern_pwm with BIT_CYCLES=1. Inputs are driven and
//   outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_pattern_pwm;

    logic       clk;
    logic       rst;
    logic       pwm_en;
    logic [7:0] duty_num;
    logic [7:0] PAT;
    logic       pwm_out;
    logic       busy;
    logic       valid;

    int checks;
    int errors;

    pattern_pwm #(
        .PAT_W      (8),
        .CNT_W      (8),
        .BIT_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_en   (pwm_en),
        .duty_num (duty_num),
        .PAT      (PAT),
        .pwm_out  (pwm_out),
        .busy     (busy),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start pulse; returns at the first RUN cycle.
    task automatic start(input logic [7:0] pat, input logic [7:0] dn);
        PAT      = pat;
        duty_num = dn;
        pwm_en   = 1'b1;
        step();
        pwm_en   = 1'b0;
    endtask

    // Called at the first RUN cycle. Follows the sequence to completion,
    // comparing every bit against the latched pattern, then checks the
    // completion strobe. mode 1 re-pulses pwm_en with a new PAT mid-run.
    task automatic drain(input string tag, input logic [7:0] pat,
                         input logic [7:0] dn, input int exp_hi,
                         input int mode);
        int cnt;
        int bad;
        int hi;
        cnt = 0;
        bad = 0;
        hi  = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            if (pwm_out !== pat[7 - (cnt % 8)]) bad++;
            if (pwm_out === 1'b1) hi++;
            if (valid !== 1'b0) bad++;
            if (mode == 1 && cnt == 3) begin
                pwm_en   = 1'b1;
                PAT      = 8'h0F;
                duty_num = 8'd0;
            end
            if (mode == 1 && cnt == 4) pwm_en = 1'b0;
            step();
            cnt++;
        end
        check({tag, "_busy_len"}, cnt, (int'(dn) + 1) * 8);
        check({tag, "_bit_err"}, bad, 0);
        check({tag, "_hi_cnt"}, hi, exp_hi);
        check({tag, "_valid"}, int'(valid), 1);
        check({tag, "_pwm_end"}, int'(pwm_out), 0);
        step();
        check({tag, "_valid_clr"}, int'(valid), 0);
    endtask

    initial begin
        int vcnt;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        pwm_en   = 1'b0;
        duty_num = 8'd0;
        PAT      = 8'd0;

        // Reset held for two cycles.
        step();
        step();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        rst = 1'b0;
        step();
        step();
        step();
        check("idle_pwm", int'(pwm_out), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(valid), 0);

        // Single pass 10101010.
        start(8'hAA, 8'd0);
        check("aa_first", int'(pwm_out), 1);
        drain("aa", 8'hAA, 8'd0, 4, 0);
        check("aa_idle_busy", int'(busy), 0);

        // Two passes of 11001100.
        start(8'hCC, 8'd1);
        drain("cc", 8'hCC, 8'd1, 8, 0);

        // Three passes of all ones: 24 high cycles.
        start(8'hFF, 8'd2);
        drain("ff", 8'hFF, 8'd2, 24, 0);

        // Max count: 256 single-cycle pulses, 2048 busy cycles.
        start(8'h80, 8'd255);
        drain("max", 8'h80, 8'd255, 256, 0);

        // Mid-run re-pulse with a different PAT is ignored.
        start(8'h96, 8'd1);
        drain("ign", 8'h96, 8'd1, 8, 1);
        check("ign_idle_busy", int'(busy), 0);

        // Reset mid-run aborts with no completion strobe.
        start(8'hAA, 8'd3);
        step();
        step();
        step();
        step();
        check("abort_busy_pre", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_pwm", int'(pwm_out), 0);
        check("abort_valid", int'(valid), 0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid !== 1'b0 || busy !== 1'b0) vcnt++;
            step();
        end
        check("abort_quiet", vcnt, 0);

        // pwm_en held through the valid cycle starts the next sequence.
        PAT      = 8'hC3;
        duty_num = 8'd0;
        pwm_en   = 1'b1;
        step();
        PAT      = 8'h3C;
        drain("b2b1", 8'hC3, 8'd0, 4, 0);
        check("b2b_busy", int'(busy), 1);
        check("b2b_first", int'(pwm_out), 0);
        pwm_en = 1'b0;
        drain("b2b2", 8'h3C, 8'd0, 4, 0);
        check("b2b_done", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
